// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V core types and the commit trace record
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int TRACE_SEQ_W = 32;

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [XLEN-1:0]        instr;
    logic [4:0]             rd;
    logic [XLEN-1:0]        rd_data;
    logic [TRACE_SEQ_W-1:0] seq;
  } commit_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - generic synchronous FIFO with occupancy count
// Caller guarantees push only when not full or when popping in the same cycle.
module trace_fifo #(
  parameter int  DEPTH = 16,
  parameter type T     = logic
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  output T                       data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
    else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; readers gate it with the count.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - commit record capture FIFO with seq tagging and drop count
// Optional COMMIT_TRACE_STALL_EN adds registered backpressure on stall_o.
module commit_trace_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int SKIP_ZERO_PC = 1,
  parameter int DROP_CNT_W   = 16
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   update_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic [XLEN-1:0]        instr_i,
  input  logic [4:0]             reg_addr_i,
  input  logic [XLEN-1:0]        reg_data_i,
  output logic                   trc_valid_o,
  input  logic                   trc_ready_i,
  output logic [XLEN-1:0]        trc_pc_o,
  output logic [XLEN-1:0]        trc_instr_o,
  output logic [4:0]             trc_rd_o,
  output logic [XLEN-1:0]        trc_rd_data_o,
  output logic [31:0]            trc_seq_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [DROP_CNT_W-1:0]  drop_cnt_o,
  output logic                   stall_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic                   cap, push, pop, drop;
  logic [CNT_W-1:0]       count;
  commit_rec_t            rec_in, head;
  logic [TRACE_SEQ_W-1:0] seq_q, seq_d;
  logic [DROP_CNT_W-1:0]  drop_q, drop_d;

  assign cap         = update_i && !((SKIP_ZERO_PC != 0) && (pc_i == '0));
  assign trc_valid_o = (count != '0);
  assign pop         = trc_valid_o && trc_ready_i;
  assign push        = cap && ((count != FULL_CNT) || pop);
  assign drop        = cap && !push;

  always_comb begin
    rec_in.pc      = pc_i;
    rec_in.instr   = instr_i;
    rec_in.rd      = reg_addr_i;
    rec_in.rd_data = (reg_addr_i == 5'd0) ? '0 : reg_data_i;
    rec_in.seq     = seq_q;
  end

  // Dropped records still consume a sequence number so the sink sees the gap.
  always_comb begin
    seq_d  = seq_q;
    drop_d = drop_q;
    if (cap) seq_d = seq_q + TRACE_SEQ_W'(1);
    if (drop && (drop_q != '1)) drop_d = drop_q + DROP_CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      seq_q  <= '0;
      drop_q <= '0;
    end else begin
      seq_q  <= seq_d;
      drop_q <= drop_d;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .T     (commit_rec_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push),
    .data_i  (rec_in),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count)
  );

  assign trc_pc_o      = trc_valid_o ? head.pc      : '0;
  assign trc_instr_o   = trc_valid_o ? head.instr   : '0;
  assign trc_rd_o      = trc_valid_o ? head.rd      : '0;
  assign trc_rd_data_o = trc_valid_o ? head.rd_data : '0;
  assign trc_seq_o     = trc_valid_o ? head.seq     : '0;
  assign count_o       = count;
  assign drop_cnt_o    = drop_q;

`ifdef COMMIT_TRACE_STALL_EN
  localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - 1);
  logic stall_q, stall_d;

  assign stall_d = (count >= STALL_CNT) && !pop;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) stall_q <= 1'b0;
    else         stall_q <= stall_d;
  end

  assign stall_o = stall_q;
`else
  assign stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb/tb_commit_trace_buffer.sv - directed self-checking bench for commit_trace_buffer
module tb_commit_trace_buffer;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        update_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic [31:0] instr_i = '0;
  logic [4:0]  reg_addr_i = '0;
  logic [31:0] reg_data_i = '0;
  logic        trc_valid_o;
  logic        trc_ready_i = 1'b0;
  logic [31:0] trc_pc_o;
  logic [31:0] trc_instr_o;
  logic [4:0]  trc_rd_o;
  logic [31:0] trc_rd_data_o;
  logic [31:0] trc_seq_o;
  logic [4:0]  count_o;
  logic [15:0] drop_cnt_o;
  logic        stall_o;

  int checks = 0;
  int errors = 0;

  commit_trace_buffer #(
    .DEPTH        (16),
    .SKIP_ZERO_PC (1),
    .DROP_CNT_W   (16)
  ) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .update_i      (update_i),
    .pc_i          (pc_i),
    .instr_i       (instr_i),
    .reg_addr_i    (reg_addr_i),
    .reg_data_i    (reg_data_i),
    .trc_valid_o   (trc_valid_o),
    .trc_ready_i   (trc_ready_i),
    .trc_pc_o      (trc_pc_o),
    .trc_instr_o   (trc_instr_o),
    .trc_rd_o      (trc_rd_o),
    .trc_rd_data_o (trc_rd_data_o),
    .trc_seq_o     (trc_seq_o),
    .count_o       (count_o),
    .drop_cnt_o    (drop_cnt_o),
    .stall_o       (stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rstn_i   = 1'b0;
    update_i = 1'b0;
    step();
    step();
    rstn_i = 1'b1;
    step();
  endtask

  task automatic commit(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data);
    update_i   = 1'b1;
    pc_i       = pc;
    instr_i    = pc ^ 32'h0000_0013;
    reg_addr_i = rd;
    reg_data_i = data;
  endtask

  initial begin
    rstn_i = 1'b0;
    step();
    check_eq("rst_valid", trc_valid_o, 0);
    check_eq("rst_count", count_o, 0);
    check_eq("rst_drop", drop_cnt_o, 0);
    check_eq("rst_stall", stall_o, 0);
    check_eq("rst_pc", trc_pc_o, 0);
    check_eq("rst_seq", trc_seq_o, 0);
    rstn_i = 1'b1;
    step();

    // Streaming with sink always ready
    trc_ready_i = 1'b1;
    commit(32'h8000_0000, 5'd1, 32'h11);
    step();
    commit(32'h8000_0004, 5'd2, 32'h22);
    check_eq("s0_pc", trc_pc_o, 32'h8000_0000);
    check_eq("s0_seq", trc_seq_o, 0);
    check_eq("s0_rd", trc_rd_o, 1);
    check_eq("s0_rdd", trc_rd_data_o, 32'h11);
    check_eq("s0_cnt", count_o, 1);
    step();
    commit(32'h8000_0008, 5'd3, 32'h33);
    check_eq("s1_pc", trc_pc_o, 32'h8000_0004);
    check_eq("s1_seq", trc_seq_o, 1);
    check_eq("s1_cnt", count_o, 1);
    step();
    update_i = 1'b0;
    check_eq("s2_pc", trc_pc_o, 32'h8000_0008);
    check_eq("s2_instr", trc_instr_o, 32'h8000_001b);
    check_eq("s2_seq", trc_seq_o, 2);
    check_eq("s2_cnt", count_o, 1);
    step();
    check_eq("s_end_valid", trc_valid_o, 0);
    check_eq("s_end_drop", drop_cnt_o, 0);

    // Overflow: 20 commits into 16 entries
    do_reset();
    trc_ready_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      commit(32'h1000 + 32'(4 * i), 5'(i + 1), 32'(i));
      step();
    end
    check_eq("ov_cnt", count_o, 16);
    check_eq("ov_drop", drop_cnt_o, 4);
    check_eq("ov_seq0", trc_seq_o, 0);
`ifdef COMMIT_TRACE_STALL_EN
    check_eq("ov_stall", stall_o, 1);
`else
    check_eq("ov_stall", stall_o, 0);
`endif
    // Full with simultaneous pop accepts the push
    trc_ready_i = 1'b1;
    commit(32'h2000, 5'd7, 32'h77);
    step();
    update_i = 1'b0;
    check_eq("fp_cnt", count_o, 16);
    check_eq("fp_drop", drop_cnt_o, 4);
    for (int k = 1; k < 16; k++) begin
      check_eq($sformatf("dr_seq%0d", k), trc_seq_o, 32'(k));
      check_eq($sformatf("dr_pc%0d", k), trc_pc_o, 32'h1000 + 32'(4 * k));
      step();
    end
    check_eq("dr_seq20", trc_seq_o, 20);
    check_eq("dr_pc20", trc_pc_o, 32'h2000);
    step();
    check_eq("dr_empty", trc_valid_o, 0);

    // Skipped pc==0, then rd==0 forces rd data to zero
    commit(32'h0, 5'd5, 32'h55);
    step();
    update_i = 1'b0;
    check_eq("sk_valid", trc_valid_o, 0);
    check_eq("sk_drop", drop_cnt_o, 4);
    trc_ready_i = 1'b0;
    commit(32'h3000, 5'd0, 32'hDEAD_BEEF);
    step();
    update_i = 1'b0;
    check_eq("z_valid", trc_valid_o, 1);
    check_eq("z_seq", trc_seq_o, 21);
    check_eq("z_rd", trc_rd_o, 0);
    check_eq("z_rdd", trc_rd_data_o, 0);

    // Head holds while sink stalls and commits keep arriving
    for (int i = 0; i < 5; i++) begin
      commit(32'h4000 + 32'(4 * i), 5'd9, 32'h99);
      step();
      check_eq($sformatf("h_pc%0d", i), trc_pc_o, 32'h3000);
      check_eq($sformatf("h_seq%0d", i), trc_seq_o, 21);
      check_eq($sformatf("h_cnt%0d", i), count_o, 32'(i + 2));
    end
    update_i = 1'b0;
    #2;
    rstn_i = 1'b0;
    #1;
    check_eq("ar_valid", trc_valid_o, 0);
    check_eq("ar_cnt", count_o, 0);
    check_eq("ar_drop", drop_cnt_o, 0);
    step();
    rstn_i = 1'b1;
    step();
    commit(32'h5000, 5'd4, 32'h44);
    step();
    update_i = 1'b0;
    check_eq("ar_seq", trc_seq_o, 0);
    check_eq("ar_cnt1", count_o, 1);

`ifdef COMMIT_TRACE_STALL_EN
    do_reset();
    trc_ready_i = 1'b0;
    for (int i = 0; i < 15; i++) begin
      commit(32'h6000 + 32'(4 * i), 5'd1, 32'h1);
      step();
    end
    update_i = 1'b0;
    check_eq("st_cnt15", count_o, 15);
    check_eq("st_pre", stall_o, 0);
    step();
    check_eq("st_on", stall_o, 1);
    trc_ready_i = 1'b1;
    step();
    trc_ready_i = 1'b0;
    check_eq("st_off", stall_o, 0);
    check_eq("st_cnt14", count_o, 14);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
